// File: rtl/tx_stm_p2s.sv
// STM-1 transmit parallel-to-serial: frame-tagged bytes enter a small FIFO and
// leave MSB-first on sdo at 155 MHz, with sof155 marking the first bit of a SOF byte.
module tx_stm_p2s #(
  parameter int unsigned FIFO_AW   = 2,
  parameter int unsigned PRIME_LVL = 2,
  parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
  input  logic               clk155,
  input  logic               rst155,
  input  logic               en,
  input  logic [7:0]         pdi,
  input  logic               pdi_sof,
  input  logic               pdi_vld,
  output logic               pdi_rdy,
  output logic               sdo,
  output logic               sof155,
  output logic               underrun,
  output logic [FIFO_AW:0]   fifo_lvl
);

  localparam int unsigned      DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] PRIME_L = (FIFO_AW + 1)'(PRIME_LVL);

  typedef struct packed {
    logic       sof;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  // ---------------------------------------------------------------- FIFO
  entry_t               mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;
  logic [FIFO_AW:0]     lvl;
  entry_t               head;
  logic                 wr_en;
  logic                 pop;
  logic                 fifo_empty;

  // Ready depends only on the registered level, so a pop never frees a slot
  // for a write in the same cycle.
  assign pdi_rdy    = (lvl != DEPTH_L);
  assign wr_en      = pdi_vld & pdi_rdy;
  assign fifo_empty = (lvl == '0);
  assign head       = mem[rd_ptr];
  assign fifo_lvl   = lvl;

  // NOTE: the storage array has no reset; pointers and level alone decide which entries are valid.
  always_ff @(posedge clk155) begin
    if (wr_en) mem[wr_ptr] <= '{sof: pdi_sof, data: pdi};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk155 or posedge rst155) begin
    if (rst155) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
    end
  end

  // ---------------------------------------------------------- serialiser
  state_t     state;
  state_t     state_nxt;
  logic [7:0] shreg;
  logic [7:0] shreg_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic       sof_nxt;
  logic       und_nxt;

  assign sdo = shreg[7];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    sof_nxt   = 1'b0;
    und_nxt   = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        shreg_nxt = '0;
        cnt_nxt   = '0;
        if (en) state_nxt = PRIME;
      end
      PRIME: begin
        cnt_nxt = '0;
        if (!en) begin
          state_nxt = IDLE;
        end else if (!fifo_empty) begin
          // Non-SOF heads are dropped so the line always starts on a frame.
          if (!head.sof) begin
            pop = 1'b1;
          end else if (lvl >= PRIME_L) begin
            pop       = 1'b1;
            shreg_nxt = head.data;
            sof_nxt   = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        shreg_nxt = {shreg[6:0], 1'b0};
        cnt_nxt   = cnt + 3'd1;
        if (cnt == 3'd7) begin
          if (!en) begin
            shreg_nxt = '0;
            state_nxt = IDLE;
          end else if (!fifo_empty) begin
            pop       = 1'b1;
            shreg_nxt = head.data;
            sof_nxt   = head.sof;
          end else begin
            shreg_nxt = IDLE_BYTE;
            und_nxt   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk155 or posedge rst155) begin
    if (rst155) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      sof155   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      cnt      <= cnt_nxt;
      sof155   <= sof_nxt;
      underrun <= und_nxt;
    end
  end

endmodule
